// File: rtl/fwd_pipeline_pkg.sv
// Shared opcode encodings and instruction field positions for the
// two-stage forwarding pipeline.
package fwd_pipeline_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned REG_AW  = 5;

  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 26;
  localparam int unsigned RD_MSB  = 25;
  localparam int unsigned RD_LSB  = 21;
  localparam int unsigned RS1_MSB = 20;
  localparam int unsigned RS1_LSB = 16;
  localparam int unsigned RS2_MSB = 15;
  localparam int unsigned RS2_LSB = 11;

  typedef enum logic [5:0] {
    OP_MOV  = 6'b010000,
    OP_NOT  = 6'b010001,
    OP_AND  = 6'b010010,
    OP_ADD  = 6'b010011,
    OP_NOR  = 6'b010100,
    OP_NAND = 6'b010101,
    OP_SUB  = 6'b010110,
    OP_SLT  = 6'b010111,
    OP_ADDI = 6'b011011,
    OP_SUBI = 6'b011110
  } opcode_e;

endpackage

// File: rtl/fwd_alu.sv
// Combinational ALU; o_known flags whether i_op is a decodable opcode.
module fwd_alu
  import fwd_pipeline_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [5:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_imm,
  output logic [DATA_W-1:0] o_result,
  output logic              o_known
);

  always_comb begin
    o_result = '0;
    o_known  = 1'b1;
    case (i_op)
      OP_MOV:  o_result = i_a;
      OP_NOT:  o_result = ~i_a;
      OP_AND:  o_result = i_a & i_b;
      OP_ADD:  o_result = i_a + i_b;
      OP_NOR:  o_result = ~(i_a | i_b);
      OP_NAND: o_result = ~(i_a & i_b);
      OP_SUB:  o_result = i_a - i_b;
      OP_SLT:  o_result[0] = ($signed(i_a) < $signed(i_b));
      OP_ADDI: o_result = i_a + i_imm;
      OP_SUBI: o_result = i_a - i_imm;
      default: o_known = 1'b0;
    endcase
  end

endmodule

// File: rtl/fwd_pipeline.sv
// Two-stage pipeline: S1 holds the fetched instruction, S2 holds the ALU
// result, which is written back to the register file one edge later.
module fwd_pipeline
  import fwd_pipeline_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned IMM_W  = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               instr_valid,
  input  logic               hold,
  output logic [DATA_W-1:0]  alu_out,
  output logic               out_valid,
  output logic [REG_AW-1:0]  out_rd
);

  localparam int unsigned RF_AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [DATA_W-1:0]  r_regs [NREGS];
  logic [INSTR_W-1:0] r_s1_instr;
  logic               r_s1_valid;

  logic [5:0]              w_op;
  logic [REG_AW-1:0]       w_rd;
  logic [REG_AW-1:0]       w_rs1;
  logic [REG_AW-1:0]       w_rs2;
  logic signed [IMM_W-1:0] w_imm_s;
  logic [DATA_W-1:0]       w_imm;
  logic [DATA_W-1:0]       w_rf1;
  logic [DATA_W-1:0]       w_rf2;
  logic [DATA_W-1:0]       w_a;
  logic [DATA_W-1:0]       w_b;
  logic [DATA_W-1:0]       w_result;
  logic                    w_known;
  logic                    w_wb_en;

  assign w_op    = r_s1_instr[OP_MSB:OP_LSB];
  assign w_rd    = r_s1_instr[RD_MSB:RD_LSB];
  assign w_rs1   = r_s1_instr[RS1_MSB:RS1_LSB];
  assign w_rs2   = r_s1_instr[RS2_MSB:RS2_LSB];
  assign w_imm_s = signed'(r_s1_instr[IMM_W-1:0]);
  assign w_imm   = DATA_W'(w_imm_s);

  // R0 and addresses beyond NREGS read as zero.
  always_comb begin
    w_rf1 = '0;
    w_rf2 = '0;
    if (w_rs1 != '0 && 32'(w_rs1) < NREGS) w_rf1 = r_regs[w_rs1[RF_AW-1:0]];
    if (w_rs2 != '0 && 32'(w_rs2) < NREGS) w_rf2 = r_regs[w_rs2[RF_AW-1:0]];
  end

  // S2 has not been written back yet, so a matching source takes it directly.
  always_comb begin
    w_a = w_rf1;
    w_b = w_rf2;
    if (out_valid && out_rd != '0 && out_rd == w_rs1) w_a = alu_out;
    if (out_valid && out_rd != '0 && out_rd == w_rs2) w_b = alu_out;
  end

  fwd_alu #(.DATA_W(DATA_W)) u_alu (
    .i_op     (w_op),
    .i_a      (w_a),
    .i_b      (w_b),
    .i_imm    (w_imm),
    .o_result (w_result),
    .o_known  (w_known)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_instr <= '0;
      r_s1_valid <= 1'b0;
      alu_out    <= '0;
      out_valid  <= 1'b0;
      out_rd     <= '0;
    end else if (!hold) begin
      if (instr_valid) r_s1_instr <= instr_in;
      r_s1_valid <= instr_valid;
      alu_out    <= w_result;
      out_valid  <= r_s1_valid && w_known;
      out_rd     <= w_rd;
    end
  end

  assign w_wb_en = !hold && out_valid && out_rd != '0 && 32'(out_rd) < NREGS;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= DATA_W'(i * 10);
    end else if (w_wb_en) begin
      r_regs[out_rd[RF_AW-1:0]] <= alu_out;
    end
  end

endmodule

// File: doc/fwd_pipeline.md
FWD_PIPELINE -- requirements
Module: fwd_pipeline

Interface
REQ-001 Parameter DATA_W, default 32, datapath and register width.
REQ-002 Parameter NREGS, default 32, register count; register address width is 5 bits, so NREGS SHALL be 32 or less.
REQ-003 Parameter IMM_W, default 11, immediate field width taken from instr_in[IMM_W-1:0].
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 instr_in  input  32  instruction: [31:26] opcode, [25:21] rd, [20:16] rs1, [15:11] rs2, [IMM_W-1:0] imm.
REQ-007 instr_valid  input  1  instr_in is sampled only when high.
REQ-008 hold  input  1  stall; when high, all pipeline and register-file state is frozen.
REQ-009 alu_out  output  DATA_W  registered EX-stage result.
REQ-010 out_valid  output  1  alu_out carries a valid, decoded instruction result.
REQ-011 out_rd  output  5  destination register of alu_out.

Function
REQ-012 Two register stages SHALL be used: S1 captures {instr_in, instr_valid}; S2 captures {alu_out, out_valid, out_rd}.
REQ-013 Latency SHALL be fixed: an instruction sampled at edge E0 has its result on alu_out after E1, and the register-file write occurs at E2.
REQ-014 Opcodes SHALL be decoded as follows:
- MOV 010000: rs1
- NOT 010001: ~rs1
- AND 010010: rs1&rs2
- ADD 010011: rs1+rs2
- NOR 010100: ~(rs1|rs2)
- NAND 010101: ~(rs1&rs2)
- SUB 010110: rs1-rs2
- SLT 010111: signed rs1<rs2 ? 1 : 0
- ADDI 011011: rs1+imm
- SUBI 011110: rs1-imm
REQ-015 imm SHALL be sign-extended from IMM_W to DATA_W.
REQ-016 Add and subtract SHALL wrap modulo 2^DATA_W; no overflow flag is produced.
REQ-017 An unknown opcode, or instr_valid low, SHALL produce out_valid=0 and no register write; alu_out is don't-care.
REQ-018 Forwarding: when S2 is valid, out_rd is nonzero, and out_rd equals an S1 source, the operand SHALL be taken from alu_out instead of the register file.
REQ-019 Register-file reads two or more instructions after a producer SHALL return the written value; no stall is ever inserted.
REQ-020 R0 SHALL read as 0; writes targeting rd=0 SHALL be discarded, but out_valid and alu_out still report the computed result.
REQ-021 While hold is high, S1, S2 and the register file SHALL retain their values and instr_in SHALL be ignored; outputs stay stable.
REQ-022 When hold deasserts, the pipeline SHALL resume exactly where it stopped, with no lost or duplicated instruction.

Reset
REQ-023 While rst=0: S1 valid=0, out_valid=0, alu_out=0, out_rd=0.
REQ-024 While rst=0, register Rx SHALL equal (x*10) mod 2^DATA_W.
REQ-025 Reset asserted mid-stream SHALL discard all in-flight instructions, including any pending write-back.

Structure
REQ-026 Opcode constants and field bit positions SHALL live in shared package fwd_pipeline_pkg.
REQ-027 The ALU SHALL be a separate combinational sub-module, fwd_alu, parametrised by DATA_W.
REQ-028 The register file, forwarding mux and pipeline registers SHALL reside in fwd_pipeline.

Verification
REQ-029 Reset, then MOV R2<-R1 -> alu_out=10, out_rd=2, out_valid=1 one edge after sampling; a later MOV R5<-R2 -> 10.
REQ-030 Back-to-back ADDI R11=R6+413 then SUBI R12=R11-413 -> alu_out=473, then 60 (forwarding path exercised).
REQ-031 Signed compare sequence -> alu_out 1, 1, 0:
- NOT R3<-R4 gives R3=-41; then SLT R3<R1 -> 1.
- SLT R28<R30 -> 1.
- SLT R30<R30 -> 0.
REQ-032 ADDI R0=R5+1 -> alu_out=51; a following MOV R2<-R0 -> 0.
REQ-033 Hold and reset mid-stream:
- Hold high for 3 cycles mid-stream: alu_out and out_valid are frozen, and results resume in order afterwards.
- rst pulsed mid-stream: out_valid drops immediately, and R11 reads 110 afterwards.
REQ-034 Width and decode edge cases:
- With DATA_W=16, ADD of R31 (=310) and SUBI-derived 0xFFFF wraps -> 309.
- Opcode 111111 -> out_valid=0 and no register change.
